// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB], parked in IDLE when start_i=0.
// Optional MULTICYCLE_MUL_EN: R-type MUL holds EXEC for MUL_CYCLES cycles via a down-counter.
module multicycle_ctrl #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [6:0] op_i,
  input  logic [9:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       mem_to_reg_o,
  output logic       alu_src_o,
  output logic       pc_src_o,
  output logic [1:0] alu_op_o,
  output logic [2:0] state_o,
  output logic       busy_o,
  output logic       illegal_o
);
  localparam logic [6:0] OpR  = 7'b0110011;
  localparam logic [6:0] OpI  = 7'b0010011;
  localparam logic [6:0] OpLd = 7'b0000011;
  localparam logic [6:0] OpSt = 7'b0100011;
  localparam logic [6:0] OpBr = 7'b1100011;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5
  } state_e;

  state_e     r_state, w_state_next, w_boundary;
  logic [6:0] r_op;
  logic [9:0] r_funct;
  logic       w_legal, w_is_r, w_is_i, w_is_ld, w_is_st, w_is_br, w_exec_done;

  assign w_legal = (op_i == OpR) || (op_i == OpI) || (op_i == OpLd) ||
                   (op_i == OpSt) || (op_i == OpBr);
  assign w_is_r  = (r_op == OpR);
  assign w_is_i  = (r_op == OpI);
  assign w_is_ld = (r_op == OpLd);
  assign w_is_st = (r_op == OpSt);
  assign w_is_br = (r_op == OpBr);
  // start_i is only consulted where an instruction would enter FETCH
  assign w_boundary = start_i ? StFetch : StIdle;

`ifdef MULTICYCLE_MUL_EN
  logic [3:0] r_mul_cnt;
  logic       w_is_mul;

  assign w_is_mul    = w_is_r && (r_funct == {7'b0000001, 3'b000});
  assign w_exec_done = !w_is_mul || (r_mul_cnt == 4'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mul_cnt <= 4'd0;
    end else if (r_state == StDecode) begin
      r_mul_cnt <= 4'(MUL_CYCLES - 1);
    end else if ((r_state == StExec) && (r_mul_cnt != 4'd0)) begin
      r_mul_cnt <= r_mul_cnt - 4'd1;
    end
  end
`else
  logic w_unused;
  assign w_unused    = ^{r_funct, 32'(MUL_CYCLES)};
  assign w_exec_done = 1'b1;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_op    <= 7'd0;
      r_funct <= 10'd0;
    end else if (r_state == StDecode) begin
      r_op    <= op_i;
      r_funct <= funct_i;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:   w_state_next = w_boundary;
      StFetch:  w_state_next = StDecode;
      StDecode: w_state_next = w_legal ? StExec : w_boundary;
      StExec: begin
        if (w_is_br) begin
          w_state_next = w_boundary;
        end else if (w_is_ld || w_is_st) begin
          w_state_next = StMem;
        end else if (w_exec_done) begin
          w_state_next = StWb;
        end
      end
      StMem: begin
        if (mem_ready_i) begin
          w_state_next = w_is_ld ? StWb : w_boundary;
        end
      end
      StWb:     w_state_next = w_boundary;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_o    = 1'b0;
    pc_src_o     = 1'b0;
    alu_op_o     = 2'b00;
    illegal_o    = 1'b0;
    case (r_state)
      StFetch: begin
        ir_write_o = 1'b1;
        pc_write_o = 1'b1;
      end
      StDecode: illegal_o = !w_legal;
      StExec: begin
        alu_src_o = w_is_i || w_is_ld || w_is_st;
        if (w_is_r) alu_op_o = 2'b10;
        if (w_is_br) begin
          pc_write_o = zero_i;
          pc_src_o   = zero_i;
        end
      end
      StMem: begin
        mem_read_o  = w_is_ld;
        mem_write_o = w_is_st;
      end
      StWb: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = w_is_ld;
      end
      default: ;
    endcase
  end

  assign state_o = r_state;
  assign busy_o  = (r_state != StIdle);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle traces are built from the
// instruction class rules, then replayed with randomized don't-care inputs.
module tb_multicycle_ctrl;
  localparam int unsigned MulCycles = 4;
`ifdef MULTICYCLE_MUL_EN
  localparam int MulExec = MulCycles;
`else
  localparam int MulExec = 1;
`endif
  localparam int KR = 0, KI = 1, KLD = 2, KST = 3, KBR = 4, KMUL = 5, KILL = 6, KBAD = 7;

  typedef struct packed {
    logic       start;
    logic [6:0] op;
    logic [9:0] funct;
    logic       zero;
    logic       ready;
  } in_t;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw, irw, rw, mr, mw, m2r, asrc, psrc;
    logic [1:0] aop;
    logic       busy, ill;
  } out_t;

  logic       clk = 1'b0;
  logic       rst, start, zero, ready;
  logic [6:0] op;
  logic [9:0] funct;
  logic       pcw, irw, rw, mr, mw, m2r, asrc, psrc, busy, ill;
  logic [1:0] aop;
  logic [2:0] st;

  in_t  in_q[$];
  out_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  multicycle_ctrl #(.MUL_CYCLES(MulCycles)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .funct_i(funct),
    .zero_i(zero), .mem_ready_i(ready), .pc_write_o(pcw), .ir_write_o(irw),
    .reg_write_o(rw), .mem_read_o(mr), .mem_write_o(mw), .mem_to_reg_o(m2r),
    .alu_src_o(asrc), .pc_src_o(psrc), .alu_op_o(aop), .state_o(st),
    .busy_o(busy), .illegal_o(ill)
  );

  always #5 clk = ~clk;

  function automatic bit is_legal(logic [6:0] o);
    return o inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
  endfunction

  function automatic logic [6:0] op_of(int k);
    logic [6:0] o;
    case (k)
      KR, KMUL: o = 7'b0110011;
      KI:       o = 7'b0010011;
      KLD:      o = 7'b0000011;
      KST:      o = 7'b0100011;
      KBR:      o = 7'b1100011;
      KBAD:     o = 7'b1111111;
      default: begin
        o = 7'($urandom);
        while (is_legal(o)) o = 7'($urandom);
      end
    endcase
    return o;
  endfunction

  function automatic in_t rand_in();
    in_t x;
    x.start = 1'($urandom_range(0, 1));
    x.op    = 7'($urandom);
    x.funct = 10'($urandom);
    x.zero  = 1'($urandom_range(0, 1));
    x.ready = 1'($urandom_range(0, 1));
    return x;
  endfunction

  function automatic out_t cyc(logic [2:0] s);
    out_t o;
    o      = '0;
    o.st   = s;
    o.busy = (s != 3'd0);
    return o;
  endfunction

  function automatic out_t outs();
    return {st, pcw, irw, rw, mr, mw, m2r, asrc, psrc, aop, busy, ill};
  endfunction

  task automatic drive(in_t x);
    @(negedge clk);
    start = x.start;
    op    = x.op;
    funct = x.funct;
    zero  = x.zero;
    ready = x.ready;
    #1;
  endtask

  // n IDLE cycles; start_i is 0 except on the last one, where it is go
  task automatic add_idle(int n, bit go);
    in_t x;
    for (int i = 0; i < n; i++) begin
      x       = rand_in();
      x.start = (i == n - 1) ? go : 1'b0;
      in_q.push_back(x);
      exp_q.push_back(cyc(3'd0));
    end
  endtask

  // mid: start_i inside the instruction (0, 1, or 2 = random); last: start_i on its final cycle
  task automatic add_instr(int k, bit z, int waits, int mid, bit last);
    logic [6:0] o;
    logic [9:0] f;
    out_t       e[$];
    in_t        v[$];
    in_t        x;
    out_t       y;
    int         n;
    o = op_of(k);
    if (k == KMUL) begin
      f = {7'b0000001, 3'b000};
    end else begin
      f = 10'($urandom);
      if (f == {7'b0000001, 3'b000}) f = 10'd0;
    end
    y = cyc(3'd1); y.pcw = 1'b1; y.irw = 1'b1;
    e.push_back(y); v.push_back(rand_in());
    y = cyc(3'd2); y.ill = !is_legal(o);
    x = rand_in(); x.op = o; x.funct = f;
    e.push_back(y); v.push_back(x);
    if (is_legal(o)) begin
      n = (k == KMUL) ? MulExec : 1;
      for (int i = 0; i < n; i++) begin
        y = cyc(3'd3); x = rand_in();
        y.asrc = (k inside {KI, KLD, KST});
        if (k == KR || k == KMUL) y.aop = 2'b10;
        if (k == KBR) begin
          x.zero = z; y.pcw = z; y.psrc = z;
        end
        e.push_back(y); v.push_back(x);
      end
      if (k == KLD || k == KST) begin
        for (int i = 0; i <= waits; i++) begin
          y = cyc(3'd4); y.mr = (k == KLD); y.mw = (k == KST);
          x = rand_in(); x.ready = (i == waits);
          e.push_back(y); v.push_back(x);
        end
      end
      if (k inside {KR, KI, KMUL, KLD}) begin
        y = cyc(3'd5); y.rw = 1'b1; y.m2r = (k == KLD);
        e.push_back(y); v.push_back(rand_in());
      end
    end
    for (int i = 0; i < v.size(); i++) begin
      x = v[i];
      if (i == v.size() - 1) x.start = last;
      else if (mid == 2) x.start = 1'($urandom_range(0, 1));
      else x.start = (mid != 0);
      in_q.push_back(x);
      exp_q.push_back(e[i]);
    end
  endtask

  task automatic test_reset();
    out_t g;
    rst = 1'b1; start = 1'b1; op = 7'b0110011; funct = 10'd0; zero = 1'b1; ready = 1'b1;
    #2;
    g = outs(); total++;
    if (g !== cyc(3'd0)) begin
      bad++; $display("FAIL reset_async: got %h want %h", g, cyc(3'd0));
    end
    @(posedge clk); #1;
    g = outs(); total++;
    if (g !== cyc(3'd0)) begin
      bad++; $display("FAIL reset_held: got %h want %h", g, cyc(3'd0));
    end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    add_idle(3, 1'b0);
    while (in_q.size() != 0) begin
      drive(in_q.pop_front()); g = outs(); total++;
      if (g !== exp_q[0]) begin
        bad++; $display("FAIL reset_idle: got %h want %h", g, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_add();
    out_t e, g;
    add_idle(1, 1'b1);
    add_instr(KR, 1'b0, 0, 1, 1'b1);
    add_instr(KI, 1'b0, 0, 1, 1'b0);
    add_idle(1, 1'b0);
    while (in_q.size() != 0) begin
      drive(in_q.pop_front()); e = exp_q.pop_front(); g = outs(); total++;
      if (g !== e) begin
        bad++; $display("FAIL add: got %h want %h (state %0d want %0d)", g, e, g.st, e.st);
      end
    end
  endtask

  task automatic test_load_store();
    out_t e, g;
    add_idle(1, 1'b1);
    add_instr(KLD, 1'b0, 3, 1, 1'b1);
    add_instr(KST, 1'b0, 2, 1, 1'b0);
    add_idle(1, 1'b0);
    while (in_q.size() != 0) begin
      drive(in_q.pop_front()); e = exp_q.pop_front(); g = outs(); total++;
      if (g !== e) begin
        bad++; $display("FAIL load_store: got %h want %h (state %0d want %0d)", g, e, g.st, e.st);
      end
    end
  endtask

  task automatic test_branch();
    out_t e, g;
    add_idle(1, 1'b1);
    add_instr(KBR, 1'b1, 0, 1, 1'b1);
    add_instr(KBR, 1'b0, 0, 1, 1'b0);
    add_idle(1, 1'b0);
    while (in_q.size() != 0) begin
      drive(in_q.pop_front()); e = exp_q.pop_front(); g = outs(); total++;
      if (g !== e) begin
        bad++; $display("FAIL branch: got %h want %h (state %0d want %0d)", g, e, g.st, e.st);
      end
    end
  endtask

  task automatic test_illegal();
    out_t e, g;
    add_idle(1, 1'b1);
    add_instr(KBAD, 1'b0, 0, 1, 1'b1);
    add_instr(KILL, 1'b0, 0, 1, 1'b0);
    add_idle(1, 1'b0);
    while (in_q.size() != 0) begin
      drive(in_q.pop_front()); e = exp_q.pop_front(); g = outs(); total++;
      if (g !== e) begin
        bad++; $display("FAIL illegal: got %h want %h (state %0d want %0d)", g, e, g.st, e.st);
      end
    end
  endtask

  task automatic test_mul();
    out_t e, g;
    add_idle(1, 1'b1);
    add_instr(KMUL, 1'b0, 0, 0, 1'b0);
    add_idle(2, 1'b0);
    while (in_q.size() != 0) begin
      drive(in_q.pop_front()); e = exp_q.pop_front(); g = outs(); total++;
      if (g !== e) begin
        bad++; $display("FAIL mul: got %h want %h (state %0d want %0d)", g, e, g.st, e.st);
      end
    end
  endtask

  task automatic test_random();
    out_t e, g;
    int   k, w;
    bit   z, last;
    add_idle(1, 1'b1);
    for (int i = 0; i < 80; i++) begin
      k    = int'($urandom_range(0, 6));
      w    = int'($urandom_range(0, 4));
      z    = 1'($urandom_range(0, 1));
      last = (i == 79) ? 1'b0 : ($urandom_range(0, 3) != 0);
      add_instr(k, z, w, 2, last);
      if (!last && i != 79) add_idle(int'($urandom_range(1, 3)), 1'b1);
    end
    add_idle(1, 1'b0);
    while (in_q.size() != 0) begin
      drive(in_q.pop_front()); e = exp_q.pop_front(); g = outs(); total++;
      if (g !== e) begin
        bad++; $display("FAIL random: got %h want %h (state %0d want %0d)", g, e, g.st, e.st);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    out_t e, g;
    add_idle(1, 1'b1);
    add_instr(KST, 1'b0, 6, 1, 1'b1);
    // IDLE, FETCH, DECODE, EXEC, first MEM wait cycle
    repeat (5) begin
      drive(in_q.pop_front()); e = exp_q.pop_front(); g = outs(); total++;
      if (g !== e) begin
        bad++; $display("FAIL mid_mem_setup: got %h want %h", g, e);
      end
    end
    in_q.delete();
    exp_q.delete();
    #2; rst = 1'b1; #1;
    total++;
    if (mw !== 1'b0 || st !== 3'd0) begin
      bad++; $display("FAIL mid_mem_reset: mem_write %b state %0d want 0 0", mw, st);
    end
    g = outs(); total++;
    if (g !== cyc(3'd0)) begin
      bad++; $display("FAIL mid_mem_outputs: got %h want %h", g, cyc(3'd0));
    end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    add_idle(1, 1'b1);
    add_instr(KR, 1'b0, 0, 1, 1'b0);
    add_idle(1, 1'b0);
    while (in_q.size() != 0) begin
      drive(in_q.pop_front()); e = exp_q.pop_front(); g = outs(); total++;
      if (g !== e) begin
        bad++; $display("FAIL post_reset: got %h want %h", g, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_store();
    test_branch();
    test_illegal();
    test_mul();
    test_random();
    test_reset_mid_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
